// File: rtl/btn_event_gen.sv
`default_nettype none
// btn_event_gen: debounced button level -> PRESS/RELEASE/LONG/REPEAT events through a valid/ready holding register.
// Rev 1.0. Define BTN_REPEAT_EN to enable REPEAT events while the button stays held in LONG.
module btn_event_gen #(
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 12_000_000,
  parameter int REPEAT_CYCLES = 3_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       held,
  output logic       evt_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

`ifdef BTN_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             btn_q;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic             rise, fall;
  logic             raise;
  logic [1:0]       raise_code;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;
  assign held = btn_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = hold_cnt;
    raise      = 1'b0;
    raise_code = EVT_PRESS;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt  = ST_PRESSED;
          raise      = 1'b1;
          raise_code = EVT_PRESS;
          cnt_nxt    = '0;
        end
      end
      ST_PRESSED: begin
        // A release on the terminal cycle wins over LONG.
        if (fall) begin
          state_nxt  = ST_IDLE;
          raise      = 1'b1;
          raise_code = EVT_RELEASE;
        end else if (hold_cnt == LONG_TERM) begin
          state_nxt  = ST_LONG;
          raise      = 1'b1;
          raise_code = EVT_LONG;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_nxt  = ST_IDLE;
          raise      = 1'b1;
          raise_code = EVT_RELEASE;
        end else if (REPEAT_EN && (hold_cnt == REPEAT_TERM)) begin
          raise      = 1'b1;
          raise_code = EVT_REPEAT;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = REPEAT_EN ? hold_cnt + 1'b1 : '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      btn_q    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      btn_q    <= btn_level;
      hold_cnt <= cnt_nxt;
    end
  end

  // One-entry holding register; the FSM never stalls, so a blocked slot drops the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_PRESS;
      evt_ovf   <= 1'b0;
    end else begin
      if (raise) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= raise_code;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_gen.sv
`default_nettype none
// Randomised and directed bench for btn_event_gen against a time-based event model.
module tb_btn_event_gen;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_level = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       held;
  logic       evt_ovf;

  int errors = 0;
  int checks = 0;

  // Reference model: events derived from the press timestamp.
  logic       m_prev, m_pressed, m_valid, m_ovf;
  logic [1:0] m_code;
  int         m_cycle = 0;
  int         m_start = 0;

  btn_event_gen #(.CNT_W(24), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .held(held), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = 0; m_pressed = 0; m_valid = 0; m_code = 2'b00; m_ovf = 0;
  endtask

  task automatic step(input logic b, input logic r);
    logic       raise;
    logic [1:0] code;
    int         k;
    btn_level = b;
    evt_ready = r;
    @(posedge clk);
    raise = 0;
    code  = 2'b00;
    if (!m_pressed && b && !m_prev) begin
      raise = 1; code = 2'b00; m_pressed = 1; m_start = m_cycle;
    end else if (m_pressed && !b && m_prev) begin
      raise = 1; code = 2'b01; m_pressed = 0;
    end else if (m_pressed) begin
      k = m_cycle - m_start;
      if (k == L) begin
        raise = 1; code = 2'b10;
      end else if (REP_EN && k > L && ((k - L) % R) == 0) begin
        raise = 1; code = 2'b11;
      end
    end
    if (raise) begin
      if (!m_valid || r) begin m_valid = 1; m_code = code; end
      else m_ovf = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    m_prev = b;
    m_cycle++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    btn_level = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({evt_valid, evt_code, held, evt_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset: got v=%b c=%b h=%b o=%b want all 0", evt_valid, evt_code, held, evt_ovf);
    end
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_short_press();
    int n_long = 0;
    for (int i = 0; i < 10; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b1);
      if (evt_valid && evt_code == 2'b10) n_long++;
      checks++;
      if ({evt_valid, evt_code, held, evt_ovf} !== {m_valid, m_code, m_prev, m_ovf}) begin
        errors++;
        $display("FAIL short[%0d]: got v=%b c=%b h=%b o=%b want v=%b c=%b h=%b o=%b", i,
                 evt_valid, evt_code, held, evt_ovf, m_valid, m_code, m_prev, m_ovf);
      end
    end
    checks++;
    if (n_long != 0 || evt_ovf !== 1'b0) begin
      errors++;
      $display("FAIL short_nolong: got longs=%0d ovf=%b want 0 0", n_long, evt_ovf);
    end
  endtask

  task automatic test_hold();
    int t_press = -1, t_long = -1, n_rep = 0, n_rel = 0;
    for (int i = 0; i < 26; i++) begin
      step((i < 20) ? 1'b1 : 1'b0, 1'b1);
      if (evt_valid && evt_code == 2'b00) t_press = i;
      if (evt_valid && evt_code == 2'b10) t_long = i;
      if (evt_valid && evt_code == 2'b11) n_rep++;
      if (evt_valid && evt_code == 2'b01) n_rel = i;
      checks++;
      if ({evt_valid, evt_code, held, evt_ovf} !== {m_valid, m_code, m_prev, m_ovf}) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b c=%b h=%b o=%b want v=%b c=%b h=%b o=%b", i,
                 evt_valid, evt_code, held, evt_ovf, m_valid, m_code, m_prev, m_ovf);
      end
    end
    checks++;
    if (t_long - t_press != L || n_rel - t_press != 20) begin
      errors++;
      $display("FAIL hold_timing: got long@+%0d release@+%0d want +%0d +20", t_long - t_press, n_rel - t_press, L);
    end
    checks++;
    if (n_rep != (REP_EN ? 2 : 0)) begin
      errors++;
      $display("FAIL hold_repeats: got %0d want %0d", n_rep, REP_EN ? 2 : 0);
    end
  endtask

  task automatic test_release_on_terminal();
    int n_long = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < L) ? 1'b1 : 1'b0, 1'b1);
      if (evt_valid && evt_code[1]) n_long++;
      if (i == L) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
          errors++;
          $display("FAIL term_release: got v=%b c=%b want v=1 c=01", evt_valid, evt_code);
        end
      end
      checks++;
      if ({evt_valid, evt_code, held, evt_ovf} !== {m_valid, m_code, m_prev, m_ovf}) begin
        errors++;
        $display("FAIL term[%0d]: got v=%b c=%b h=%b o=%b want v=%b c=%b h=%b o=%b", i,
                 evt_valid, evt_code, held, evt_ovf, m_valid, m_code, m_prev, m_ovf);
      end
    end
    checks++;
    if (n_long != 0) begin
      errors++;
      $display("FAIL term_nolong: got %0d long/repeat want 0", n_long);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if ({evt_valid, evt_code, evt_ovf} !== 4'b1001) begin
      errors++;
      $display("FAIL bp_hold: got v=%b c=%b o=%b want v=1 c=00 o=1", evt_valid, evt_code, evt_ovf);
    end
    step(1'b0, 1'b1);
    checks++;
    if ({evt_valid, evt_ovf} !== 2'b01 || {m_valid, m_ovf} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drain: got v=%b o=%b want v=0 o=1", evt_valid, evt_ovf);
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({evt_valid, evt_code, held, evt_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async: got v=%b c=%b h=%b o=%b want all 0", evt_valid, evt_code, held, evt_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({evt_valid, held} !== 2'b00) begin
      errors++;
      $display("FAIL rst_hold: got v=%b h=%b want 0 0", evt_valid, held);
    end
    #2 rst_n = 1;
    step(1'b1, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b00 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_press: got v=%b c=%b want v=1 c=00", evt_valid, evt_code);
    end
  endtask

  task automatic test_random();
    logic b = btn_level;
    logic r;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) b = ~b;
      r = ($urandom_range(0, 3) != 0);
      step(b, r);
      checks++;
      if ({evt_valid, evt_code, held, evt_ovf} !== {m_valid, m_code, m_prev, m_ovf}) begin
        errors++;
        $display("FAIL rand[%0d]: got v=%b c=%b h=%b o=%b want v=%b c=%b h=%b o=%b", i,
                 evt_valid, evt_code, held, evt_ovf, m_valid, m_code, m_prev, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold();
    test_release_on_terminal();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
